limb_master: RTL and testbench
==============================

LIMB_MASTER -- requirements
Module: limb_master

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per limb_clk half-period, legal range 1..255.
REQ-002 Parameter WAIT_TIMEOUT, default 1023: maximum limb_clk periods spent waiting on limb_nwait before the transfer is aborted.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- wb_adr_i  in  36  Wishbone word address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte selects.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  timeout error.
- limb_d_out  out  8  LIMB data driven by this block.
- limb_d_in  in  8  LIMB data from the bus.
- limb_d_oe  out  1  data output enable; the toplevel merges d_in, d_out and d_oe into one inout.
- limb_clk  out  1  LIMB bus clock.
- limb_nrd  out  1  low during the read phase.
- limb_start  out  1  high during header byte 0 only.
- limb_nwait  in  1  low while the remote responder is busy.

Function
REQ-004 This block is the LIMB initiator and a Wishbone slave; one LIMB frame is issued per Wishbone cycle.
REQ-005 limb_clk timing:
- limb_clk toggles every CLK_DIV clk cycles while a frame is active and is held low while idle.
- Outputs change only coincident with a limb_clk falling edge.
- limb_d_in and limb_nwait are sampled on the clk cycle that produces a limb_clk rising edge.
REQ-006 Frame accepted when wb_cyc_i && wb_stb_i are high in IDLE; wb_adr_i, wb_dat_i, wb_we_i and wb_sel_i are registered in that cycle.
REQ-007 Header: 6 bytes, one per limb_clk period, limb_d_oe=1.
- byte0 = {we, 3'b000, sel[3:0]}.
- byte1 = {4'b0000, adr[35:32]}.
- bytes 2..5 = adr[31:0], MSB byte first.
REQ-008 Write frame: 4 data bytes follow the header, dat[31:24] first, limb_d_oe=1; the block then enters WAIT.
REQ-009 Read frame: after the header, limb_d_oe=0 and limb_nrd=0 for one turnaround period, then WAIT.
REQ-010 WAIT state:
- Sample limb_nwait each rising edge.
- First sample high: a read goes to RDATA; a write goes to DONE.
- Turnaround and WAIT periods count toward WAIT_TIMEOUT.
REQ-011 RDATA:
- 4 bytes are captured on 4 consecutive rising edges, MSB first, into wb_dat_o.
- limb_nrd stays 0 throughout; limb_nrd returns to 1 at the falling edge after the last byte.
REQ-012 DONE: wb_ack_o pulses high for exactly 1 clk; limb_clk is forced low; the block returns to IDLE.
REQ-013 Timeout: if limb_nwait is still low after WAIT_TIMEOUT rising edges:
- wb_err_o pulses for 1 clk instead of wb_ack_o.
- limb_d_oe=0, limb_nrd=1, and the block returns to IDLE.
REQ-014 States: IDLE, HDR, WDATA, TURN, WAIT, RDATA, DONE, ERR; the byte counter is 3 bits and the timeout counter is 10 bits.
REQ-015 If wb_cyc_i drops mid-frame, the frame is still completed, but wb_ack_o and wb_err_o are suppressed.
REQ-016 wb_dat_o holds the last read value until the next read completes; it does not change on write frames.
REQ-017 limb_d_oe is never high while limb_nrd=0.
REQ-018 Back-to-back requests: at least one idle limb_clk period (2*CLK_DIV clk) separates frames.

Reset
REQ-019 While reset=0, asynchronously force:
- state=IDLE, limb_clk=0, limb_d_oe=0, limb_d_out=8'h00, limb_nrd=1, limb_start=0.
- wb_ack_o=0, wb_err_o=0, wb_dat_o=32'h0, all counters cleared.
REQ-020 Reset asserted mid-frame aborts the frame immediately; no ack or err is issued after release.
REQ-021 The first frame may be accepted on the first clk edge after reset deasserts.

Verification
REQ-022 Write with CLK_DIV=2, adr=36'h9_1234_5678, dat=32'hDEADBEEF, sel=4'hF, nwait tied high -> LIMB bytes are:
- 8F 09 12 34 56 78 DE AD BE EF.
- limb_start is high only for 8F.
- wb_ack_o pulses once.
REQ-023 Read with adr=36'h0_0000_0004, sel=4'hF, responder holding nwait low for 5 rising edges then returning bytes 01 02 03 04 -> wb_dat_o=32'h01020304 and one ack; limb_d_oe=0 whenever nrd=0.
REQ-024 WAIT_TIMEOUT=8, nwait stuck low -> wb_err_o pulses once after 8 wait edges; no ack; limb_nrd=1 and limb_d_oe=0 afterwards.
REQ-025 Reset asserted during write data byte 2 -> all outputs take their REQ-019 values immediately; no ack; the next request completes normally.
REQ-026 wb_cyc_i dropped during the header -> the full frame still appears on LIMB; no ack.
REQ-027 Loopback against the existing limb_interface + 64-byte wb_ram: write then read 16 words -> every readback matches.

Source files
------------

// File: rtl/limb_master.sv
// LIMB bus initiator with a Wishbone slave front end.
// Each Wishbone cycle becomes one LIMB frame; limb_clk is derived from clk by CLK_DIV.
module limb_master #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned WAIT_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [35:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  limb_d_out,
  input  logic [7:0]  limb_d_in,
  output logic        limb_d_oe,
  output logic        limb_clk,
  output logic        limb_nrd,
  output logic        limb_start,
  input  logic        limb_nwait
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned TMO_W = 10;
  localparam int unsigned GAP_W = 9;
  localparam int unsigned CNT_W = 3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, HDR, WDATA, TURN, WAIT, RDATA, DONE, ERR} state_t;

  state_t           state_q, state_nxt;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_nxt;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_nxt;
  logic [35:0]      req_adr_q, req_adr_nxt;
  logic [31:0]      req_dat_q, req_dat_nxt;
  logic             req_we_q, req_we_nxt;
  logic [3:0]       req_sel_q, req_sel_nxt;
  logic             cyc_lost_q, cyc_lost_nxt;
  logic [31:0]      rd_shift_q, rd_shift_nxt;
  logic [31:0]      wb_dat_nxt;
  logic             wb_ack_nxt, wb_err_nxt;
  logic [7:0]       d_out_nxt;
  logic             d_oe_nxt, lclk_nxt, nrd_nxt, start_nxt;
  logic             tick, rise, fall;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic we,
                                          input logic [3:0] sel, input logic [35:0] adr);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {we, 3'b000, sel};
      3'd1:    b = {4'b0000, adr[35:32]};
      3'd2:    b = adr[31:24];
      3'd3:    b = adr[23:16];
      3'd4:    b = adr[15:8];
      default: b = adr[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] dat_byte(input logic [1:0] idx, input logic [31:0] dat);
    logic [7:0] b;
    case (idx)
      2'd0:    b = dat[31:24];
      2'd1:    b = dat[23:16];
      2'd2:    b = dat[15:8];
      default: b = dat[7:0];
    endcase
    return b;
  endfunction

  // limb_clk edge strobes: a rising edge is produced on the cycle where tick && !limb_clk
  assign tick = (div_cnt_q == DIV_LAST);
  assign rise = tick && !limb_clk;
  assign fall = tick && limb_clk;

  always_comb begin
    state_nxt    = state_q;
    div_cnt_nxt  = div_cnt_q;
    byte_cnt_nxt = byte_cnt_q;
    tmo_cnt_nxt  = tmo_cnt_q;
    gap_cnt_nxt  = gap_cnt_q;
    req_adr_nxt  = req_adr_q;
    req_dat_nxt  = req_dat_q;
    req_we_nxt   = req_we_q;
    req_sel_nxt  = req_sel_q;
    cyc_lost_nxt = cyc_lost_q;
    rd_shift_nxt = rd_shift_q;
    wb_dat_nxt   = wb_dat_o;
    wb_ack_nxt   = 1'b0;
    wb_err_nxt   = 1'b0;
    d_out_nxt    = limb_d_out;
    d_oe_nxt     = limb_d_oe;
    lclk_nxt     = limb_clk;
    nrd_nxt      = limb_nrd;
    start_nxt    = limb_start;

    if (state_q inside {HDR, WDATA, TURN, WAIT, RDATA}) begin
      div_cnt_nxt = tick ? '0 : DIV_W'(div_cnt_q + 8'd1);
      lclk_nxt    = limb_clk ^ tick;
      if (!wb_cyc_i) cyc_lost_nxt = 1'b1;
    end

    case (state_q)
      IDLE: begin
        div_cnt_nxt = '0;
        lclk_nxt    = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          state_nxt    = HDR;
          req_adr_nxt  = wb_adr_i;
          req_dat_nxt  = wb_dat_i;
          req_we_nxt   = wb_we_i;
          req_sel_nxt  = wb_sel_i;
          byte_cnt_nxt = '0;
          tmo_cnt_nxt  = '0;
          gap_cnt_nxt  = '0;
          cyc_lost_nxt = 1'b0;
          d_out_nxt    = {wb_we_i, 3'b000, wb_sel_i};
          d_oe_nxt     = 1'b1;
          nrd_nxt      = 1'b1;
          start_nxt    = 1'b1;
        end
      end
      HDR: begin
        if (fall) begin
          start_nxt = 1'b0;
          if (byte_cnt_q == 3'd5) begin
            byte_cnt_nxt = '0;
            if (req_we_q) begin
              state_nxt = WDATA;
              d_out_nxt = req_dat_q[31:24];
            end else begin
              state_nxt = TURN;
              d_out_nxt = 8'h00;
              d_oe_nxt  = 1'b0;
              nrd_nxt   = 1'b0;
            end
          end else begin
            byte_cnt_nxt = CNT_W'(byte_cnt_q + 3'd1);
            d_out_nxt    = hdr_byte(CNT_W'(byte_cnt_q + 3'd1), req_we_q, req_sel_q, req_adr_q);
          end
        end
      end
      WDATA: begin
        if (fall) begin
          if (byte_cnt_q == 3'd3) begin
            state_nxt = WAIT;
            d_out_nxt = 8'h00;
            d_oe_nxt  = 1'b0;
          end else begin
            byte_cnt_nxt = CNT_W'(byte_cnt_q + 3'd1);
            d_out_nxt    = dat_byte(2'(byte_cnt_q + 3'd1), req_dat_q);
          end
        end
      end
      TURN: begin
        if (rise) tmo_cnt_nxt = TMO_W'(tmo_cnt_q + 10'd1);
        if (fall) state_nxt = WAIT;
      end
      WAIT: begin
        if (rise) begin
          if (limb_nwait) begin
            byte_cnt_nxt = '0;
            state_nxt    = req_we_q ? DONE : RDATA;
          end else if (tmo_cnt_q >= TMO_LAST) begin
            state_nxt = ERR;
          end else begin
            tmo_cnt_nxt = TMO_W'(tmo_cnt_q + 10'd1);
          end
        end
      end
      RDATA: begin
        if (rise && byte_cnt_q != 3'd4) begin
          rd_shift_nxt = {rd_shift_q[23:0], limb_d_in};
          byte_cnt_nxt = CNT_W'(byte_cnt_q + 3'd1);
        end
        if (fall && byte_cnt_q == 3'd4) begin
          state_nxt  = DONE;
          nrd_nxt    = 1'b1;
          wb_dat_nxt = rd_shift_q;
        end
      end
      DONE, ERR: begin
        // Hold limb_clk low for one full idle period before accepting the next frame
        div_cnt_nxt = '0;
        lclk_nxt    = 1'b0;
        d_oe_nxt    = 1'b0;
        d_out_nxt   = 8'h00;
        nrd_nxt     = 1'b1;
        start_nxt   = 1'b0;
        if (gap_cnt_q == '0) begin
          wb_ack_nxt = (state_q == DONE) && !cyc_lost_q && wb_cyc_i;
          wb_err_nxt = (state_q == ERR) && !cyc_lost_q && wb_cyc_i;
        end
        if (gap_cnt_q == GAP_LAST) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = GAP_W'(gap_cnt_q + 9'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      req_adr_q  <= '0;
      req_dat_q  <= '0;
      req_we_q   <= 1'b0;
      req_sel_q  <= '0;
      cyc_lost_q <= 1'b0;
      rd_shift_q <= '0;
      wb_dat_o   <= 32'h0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      limb_d_out <= 8'h00;
      limb_d_oe  <= 1'b0;
      limb_clk   <= 1'b0;
      limb_nrd   <= 1'b1;
      limb_start <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      div_cnt_q  <= div_cnt_nxt;
      byte_cnt_q <= byte_cnt_nxt;
      tmo_cnt_q  <= tmo_cnt_nxt;
      gap_cnt_q  <= gap_cnt_nxt;
      req_adr_q  <= req_adr_nxt;
      req_dat_q  <= req_dat_nxt;
      req_we_q   <= req_we_nxt;
      req_sel_q  <= req_sel_nxt;
      cyc_lost_q <= cyc_lost_nxt;
      rd_shift_q <= rd_shift_nxt;
      wb_dat_o   <= wb_dat_nxt;
      wb_ack_o   <= wb_ack_nxt;
      wb_err_o   <= wb_err_nxt;
      limb_d_out <= d_out_nxt;
      limb_d_oe  <= d_oe_nxt;
      limb_clk   <= lclk_nxt;
      limb_nrd   <= nrd_nxt;
      limb_start <= start_nxt;
    end
  end

endmodule

// File: tb/tb_limb_master.sv
// Scoreboard bench for limb_master: expected LIMB bytes and Wishbone responses are queued at issue
// and popped by a monitor that also plays a memory-backed LIMB responder.
module tb_limb_master;
  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned WAIT_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [35:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o, wb_err_o;
  logic [7:0]  limb_d_out;
  logic [7:0]  limb_d_in = 8'h00;
  logic        limb_d_oe, limb_clk, limb_nrd, limb_start;
  logic        limb_nwait = 1'b1;

  always #5 clk = ~clk;

  limb_master #(.CLK_DIV(CLK_DIV), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .limb_d_out(limb_d_out), .limb_d_in(limb_d_in), .limb_d_oe(limb_d_oe),
    .limb_clk(limb_clk), .limb_nrd(limb_nrd), .limb_start(limb_start), .limb_nwait(limb_nwait)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          rises;
  } resp_t;

  resp_t       exp_resp[$];
  logic [8:0]  exp_byte[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [16];
  logic [7:0]  fb [10];
  bit          stuck_low = 1'b0;
  int          wait_lo = 0;
  int          rd_edges = 0;
  int          wait_rises = 0;
  int          fb_n = 0;
  logic        prev_lclk = 1'b0;
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor, scoreboard and responder share one process so the frame buffer has a single owner
  always @(negedge clk) begin
    logic        r;
    resp_t       rs;
    logic [8:0]  eb;
    logic [31:0] word;
    int          e, k;
    if (!reset) begin
      prev_lclk  = 1'b0;
      rd_edges   = 0;
      wait_rises = 0;
      fb_n       = 0;
      limb_nwait = 1'b1;
      limb_d_in  = 8'h00;
    end else begin
      check("oe_while_nrd_low", 64'(limb_d_oe & ~limb_nrd), 64'd0);
      r = limb_clk && !prev_lclk;
      if (r) begin
        if (limb_d_oe) begin
          if (exp_byte.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", limb_d_out);
          end else begin
            eb = exp_byte.pop_front();
            check("limb_byte", 64'({limb_start, limb_d_out}), 64'(eb));
          end
          if (limb_start) fb_n = 0;
          if (fb_n < 10) fb[fb_n] = limb_d_out;
          fb_n++;
          if (fb_n == 10 && fb[0][7]) mem[fb[5][3:0]] = {fb[6], fb[7], fb[8], fb[9]};
          wait_rises = 0;
        end else begin
          wait_rises++;
        end
        if (!limb_nrd) rd_edges++;
      end
      if (limb_nrd) rd_edges = 0;
      prev_lclk = limb_clk;

      if (wb_ack_o || wb_err_o) begin
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=ack%0b/err%0b required=none", wb_ack_o, wb_err_o);
        end else begin
          rs = exp_resp.pop_front();
          check("resp_err", 64'(wb_err_o), 64'(rs.is_err));
          check("resp_ack", 64'(wb_ack_o), 64'(!rs.is_err));
          check("wait_rises", 64'(wait_rises), 64'(rs.rises));
          check("wb_dat_o", 64'(wb_dat_o), 64'(rs.data));
        end
      end

      e = rd_edges + 1;
      if (stuck_low)      limb_nwait = 1'b0;
      else if (limb_nrd)  limb_nwait = 1'b1;
      else                limb_nwait = (e >= wait_lo + 2);
      word = mem[fb[5][3:0]];
      k    = e - (wait_lo + 3);
      limb_d_in = (!limb_nrd && k >= 0 && k < 4) ? 8'(word >> (8 * (3 - k))) : 8'h00;
    end
  end

  // kind: 0 = ack, 1 = err, 2 = no response; drop > 0 drops cyc that many cycles after limb_start
  task automatic wb_issue(input bit we, input logic [35:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int kind, input int rises,
                          input logic [31:0] rdat, input int drop);
    bit got;
    exp_byte.push_back({1'b1, we, 3'b000, sel});
    exp_byte.push_back({1'b0, 4'b0000, adr[35:32]});
    exp_byte.push_back({1'b0, adr[31:24]});
    exp_byte.push_back({1'b0, adr[23:16]});
    exp_byte.push_back({1'b0, adr[15:8]});
    exp_byte.push_back({1'b0, adr[7:0]});
    if (we) begin
      exp_byte.push_back({1'b0, dat[31:24]});
      exp_byte.push_back({1'b0, dat[23:16]});
      exp_byte.push_back({1'b0, dat[15:8]});
      exp_byte.push_back({1'b0, dat[7:0]});
    end
    if (kind != 2) exp_resp.push_back('{is_err: (kind == 1), data: rdat, rises: rises});
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    if (drop > 0) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        got = limb_start;
      end
      check("frame_started", 64'(got), 64'd1);
      repeat (drop) @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (400) @(negedge clk);
    end else begin
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        @(negedge clk);
        got = wb_ack_o || wb_err_o;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL response_timeout actual=none required=kind%0d", kind);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (2 * CLK_DIV + 2) @(negedge clk);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_lclk"},  64'(limb_clk),   64'd0);
    check({tag, "_oe"},    64'(limb_d_oe),  64'd0);
    check({tag, "_dout"},  64'(limb_d_out), 64'h00);
    check({tag, "_nrd"},   64'(limb_nrd),   64'd1);
    check({tag, "_start"}, 64'(limb_start), 64'd0);
    check({tag, "_ack"},   64'(wb_ack_o),   64'd0);
    check({tag, "_err"},   64'(wb_err_o),   64'd0);
    check({tag, "_dat"},   64'(wb_dat_o),   64'h0);
  endtask

  initial begin
    bit          got;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int i = 0; i < 10; i++) fb[i] = 8'h00;
    mem[4] = 32'h01020304;

    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    reset = 1'b1;

    wb_issue(1'b1, 36'h9_1234_5678, 32'hDEADBEEF, 4'hF, 0, 1, last_rd, 0);

    wait_lo = 5;
    last_rd = 32'h01020304;
    wb_issue(1'b0, 36'h0_0000_0004, 32'h0, 4'hF, 0, 11, last_rd, 0);
    wait_lo = 0;

    wb_issue(1'b1, 36'hA_0000_0010, 32'h11223344, 4'h3, 0, 1, last_rd, 0);

    stuck_low = 1'b1;
    wb_issue(1'b1, 36'h0_0000_0000, 32'h0, 4'h1, 1, 8, last_rd, 0);
    check("tmo_w_nrd", 64'(limb_nrd), 64'd1);
    check("tmo_w_oe",  64'(limb_d_oe), 64'd0);
    wb_issue(1'b0, 36'h0_0000_0020, 32'h0, 4'hF, 1, 8, last_rd, 0);
    check("tmo_r_nrd", 64'(limb_nrd), 64'd1);
    check("tmo_r_oe",  64'(limb_d_oe), 64'd0);
    stuck_low = 1'b0;

    // Reset while data byte 2 (F0) is on the bus: only the bytes before it are clocked out
    exp_byte.push_back(9'h18F);
    exp_byte.push_back(9'h001);
    exp_byte.push_back(9'h000);
    exp_byte.push_back(9'h000);
    exp_byte.push_back(9'h000);
    exp_byte.push_back(9'h000);
    exp_byte.push_back(9'h0CA);
    exp_byte.push_back(9'h0FE);
    @(negedge clk);
    wb_adr_i = 36'h1_0000_0000; wb_dat_i = 32'hCAFEF00D; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = limb_d_oe && (limb_d_out == 8'hF0);
    end
    check("reached_data_byte2", 64'(got), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_outs("midreset");
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    last_rd = 32'h0;
    repeat (4) @(negedge clk);
    check("reset_queue_drained", 64'(exp_byte.size()), 64'd0);
    reset = 1'b1;

    wb_issue(1'b1, 36'h0_0000_0003, 32'h0BADF00D, 4'hF, 0, 1, last_rd, 0);

    wb_issue(1'b1, 36'h2_0000_0008, 32'h55AA55AA, 4'hF, 2, 0, last_rd, 6);

    for (int i = 0; i < 16; i++) begin
      d = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      wb_issue(1'b1, 36'(i), d, 4'hF, 0, 1, last_rd, 0);
    end
    for (int i = 0; i < 16; i++) begin
      wait_lo = i % 3;
      last_rd = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      wb_issue(1'b0, 36'(i), 32'h0, 4'hF, 0, wait_lo + 6, last_rd, 0);
    end

    repeat (20) @(negedge clk);
    check("bytes_left", 64'(exp_byte.size()), 64'd0);
    check("resps_left", 64'(exp_resp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
